// File: rtl/bridge_sleep_seq.sv
// Sleep/wake sequencer for the AHB-AHB and AHB-APB bridges: gates and drains the
// source AHB, walks the bridge sleep handshakes downstream-first, and unwinds them on wake.
module bridge_sleep_seq #(
  parameter int unsigned IDLE_CYC = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sleep_req,
  input  logic [1:0] i_htrans,
  input  logic       i_hready,
  output logic       o_bus_gate,
  output logic       o_apb_sink_sleep_req,
  output logic       o_apb_src_sleep_req,
  input  logic       i_apb_sink_sleep_ack,
  input  logic       i_apb_src_sleep_ack,
  output logic       o_ahb_sink_sleep_req,
  output logic       o_ahb_src_sleep_req,
  input  logic       i_ahb_sink_sleep_ack,
  input  logic       i_ahb_src_sleep_ack,
  output logic       o_sleep_ack,
  output logic       o_timeout_err
);

  // state      | meaning
  // RUN        | bus open, no bridge requests
  // DRAIN      | bus gated, counting consecutive idle cycles
  // APB_SINK.. | entry steps: raise one request, wait for its ack high
  // SLEEP      | all bridges asleep, o_sleep_ack high
  // W_AHB_SRC..| wake steps: drop one request, wait for its ack low
  // ABORT      | step timed out: requests dropped, wait for all acks low
  typedef enum logic [3:0] {
    RUN, DRAIN,
    APB_SINK, APB_SRC, AHB_SINK, AHB_SRC,
    SLEEP,
    W_AHB_SRC, W_AHB_SINK, W_APB_SRC, W_APB_SINK,
    ABORT
  } state_t;

  localparam logic [7:0] IDLE_TC   = 8'(IDLE_CYC - 1);
  localparam logic [7:0] STEP_LOAD = 8'(TIMEOUT - 1);

  state_t     state, state_nxt, step_adv;
  logic [7:0] idle_cnt, idle_cnt_nxt;
  logic [7:0] step_tmr, step_tmr_nxt;
  logic       retry_blk, retry_blk_nxt;
  logic       is_step, ack_ok, bus_idle;
  logic       gate_nxt, apb_sink_nxt, apb_src_nxt, ahb_sink_nxt, ahb_src_nxt;
  logic       sleep_ack_nxt, timeout_nxt;

  // Only htrans[1] distinguishes active transfers from IDLE/BUSY.
  logic       unused_htrans0;
  assign unused_htrans0 = i_htrans[0];

  assign bus_idle = !i_htrans[1] && i_hready;

  always_comb begin
    state_nxt     = state;
    step_adv      = state;
    idle_cnt_nxt  = 8'd0;
    step_tmr_nxt  = step_tmr;
    retry_blk_nxt = retry_blk;
    is_step       = 1'b0;
    ack_ok        = 1'b0;

    case (state)
      RUN:        if (i_sleep_req && !retry_blk) state_nxt = DRAIN;
      DRAIN: begin
        if (!i_sleep_req) begin
          state_nxt = RUN;
        end else if (bus_idle) begin
          if (idle_cnt == IDLE_TC) state_nxt = APB_SINK;
          else idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      APB_SINK:   begin is_step = 1'b1; ack_ok =  i_apb_sink_sleep_ack; step_adv = APB_SRC;    end
      APB_SRC:    begin is_step = 1'b1; ack_ok =  i_apb_src_sleep_ack;  step_adv = AHB_SINK;   end
      AHB_SINK:   begin is_step = 1'b1; ack_ok =  i_ahb_sink_sleep_ack; step_adv = AHB_SRC;    end
      AHB_SRC:    begin is_step = 1'b1; ack_ok =  i_ahb_src_sleep_ack;  step_adv = SLEEP;      end
      SLEEP:      if (!i_sleep_req) state_nxt = W_AHB_SRC;
      W_AHB_SRC:  begin is_step = 1'b1; ack_ok = !i_ahb_src_sleep_ack;  step_adv = W_AHB_SINK; end
      W_AHB_SINK: begin is_step = 1'b1; ack_ok = !i_ahb_sink_sleep_ack; step_adv = W_APB_SRC;  end
      W_APB_SRC:  begin is_step = 1'b1; ack_ok = !i_apb_src_sleep_ack;  step_adv = W_APB_SINK; end
      W_APB_SINK: begin is_step = 1'b1; ack_ok = !i_apb_sink_sleep_ack; step_adv = RUN;        end
      ABORT: begin
        if (!(i_apb_sink_sleep_ack || i_apb_src_sleep_ack ||
              i_ahb_sink_sleep_ack || i_ahb_src_sleep_ack))
          state_nxt = RUN;
      end
      default:    state_nxt = RUN;
    endcase

    // An ack that arrives on the terminal-count cycle still wins over the timeout.
    if (is_step) begin
      if (ack_ok) state_nxt = step_adv;
      else if (step_tmr == 8'd0) state_nxt = ABORT;
    end

    if (state_nxt != state) step_tmr_nxt = STEP_LOAD;
    else if (is_step) step_tmr_nxt = step_tmr - 8'd1;

    timeout_nxt = (state_nxt == ABORT) && (state != ABORT);
    if (timeout_nxt) retry_blk_nxt = 1'b1;
    else if (!i_sleep_req) retry_blk_nxt = 1'b0;

    gate_nxt      = (state_nxt != RUN);
    apb_sink_nxt  = state_nxt inside {APB_SINK, APB_SRC, AHB_SINK, AHB_SRC, SLEEP,
                                      W_AHB_SRC, W_AHB_SINK, W_APB_SRC};
    apb_src_nxt   = state_nxt inside {APB_SRC, AHB_SINK, AHB_SRC, SLEEP,
                                      W_AHB_SRC, W_AHB_SINK};
    ahb_sink_nxt  = state_nxt inside {AHB_SINK, AHB_SRC, SLEEP, W_AHB_SRC};
    ahb_src_nxt   = state_nxt inside {AHB_SRC, SLEEP};
    sleep_ack_nxt = (state_nxt == SLEEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= RUN;
      idle_cnt             <= 8'd0;
      step_tmr             <= STEP_LOAD;
      retry_blk            <= 1'b0;
      o_bus_gate           <= 1'b0;
      o_apb_sink_sleep_req <= 1'b0;
      o_apb_src_sleep_req  <= 1'b0;
      o_ahb_sink_sleep_req <= 1'b0;
      o_ahb_src_sleep_req  <= 1'b0;
      o_sleep_ack          <= 1'b0;
      o_timeout_err        <= 1'b0;
    end else begin
      state                <= state_nxt;
      idle_cnt             <= idle_cnt_nxt;
      step_tmr             <= step_tmr_nxt;
      retry_blk            <= retry_blk_nxt;
      o_bus_gate           <= gate_nxt;
      o_apb_sink_sleep_req <= apb_sink_nxt;
      o_apb_src_sleep_req  <= apb_src_nxt;
      o_ahb_sink_sleep_req <= ahb_sink_nxt;
      o_ahb_src_sleep_req  <= ahb_src_nxt;
      o_sleep_ack          <= sleep_ack_nxt;
      o_timeout_err        <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bridge_sleep_seq.sv
// Bench for bridge_sleep_seq: a ladder-level reference model predicts every output change
// (value and cycle) into a queue that a negedge monitor pops; directed scenarios add timing checks.
module tb_bridge_sleep_seq;

  localparam int IDLE_CYC = 4;
  localparam int TIMEOUT  = 16;

  logic       i_clk, i_rst, i_sleep_req, i_hready;
  logic [1:0] i_htrans;
  logic       o_bus_gate, o_apb_sink_sleep_req, o_apb_src_sleep_req;
  logic       o_ahb_sink_sleep_req, o_ahb_src_sleep_req, o_sleep_ack, o_timeout_err;
  logic       i_apb_sink_sleep_ack, i_apb_src_sleep_ack, i_ahb_sink_sleep_ack, i_ahb_src_sleep_ack;

  bridge_sleep_seq #(.IDLE_CYC(IDLE_CYC), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sleep_req(i_sleep_req),
    .i_htrans(i_htrans), .i_hready(i_hready),
    .o_bus_gate(o_bus_gate),
    .o_apb_sink_sleep_req(o_apb_sink_sleep_req), .o_apb_src_sleep_req(o_apb_src_sleep_req),
    .i_apb_sink_sleep_ack(i_apb_sink_sleep_ack), .i_apb_src_sleep_ack(i_apb_src_sleep_ack),
    .o_ahb_sink_sleep_req(o_ahb_sink_sleep_req), .o_ahb_src_sleep_req(o_ahb_src_sleep_req),
    .i_ahb_sink_sleep_ack(i_ahb_sink_sleep_ack), .i_ahb_src_sleep_ack(i_ahb_src_sleep_ack),
    .o_sleep_ack(o_sleep_ack), .o_timeout_err(o_timeout_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    int unsigned cyc;
    logic [6:0]  vec;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // bit order: 0 gate, 1 apb_sink, 2 apb_src, 3 ahb_sink, 4 ahb_src, 5 sleep_ack, 6 timeout_err
  function automatic logic [6:0] dut_vec();
    return {o_timeout_err, o_sleep_ack, o_ahb_src_sleep_req, o_ahb_sink_sleep_req,
            o_apb_src_sleep_req, o_apb_sink_sleep_req, o_bus_gate};
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: the bridges form a ladder of four requests; lvl = rungs currently raised.
  localparam int M_RUN = 0, M_DRAIN = 1, M_UP = 2, M_SLEEP = 3, M_DOWN = 4, M_ABORT = 5;
  int         m_mode = M_RUN, m_lvl = 0, m_idle = 0, m_wait = 0;
  bit         m_blk = 1'b0, m_err = 1'b0;
  logic [6:0] exp_prev;

  task automatic model_step();
    logic [3:0] a;
    bit idle, to_abort;
    a = {i_ahb_src_sleep_ack, i_ahb_sink_sleep_ack, i_apb_src_sleep_ack, i_apb_sink_sleep_ack};
    idle = !i_htrans[1] && i_hready;
    to_abort = 1'b0;
    m_err = 1'b0;
    if (i_rst) begin
      m_mode = M_RUN; m_lvl = 0; m_idle = 0; m_wait = 0; m_blk = 1'b0;
    end else begin
      case (m_mode)
        M_RUN: if (i_sleep_req && !m_blk) begin m_mode = M_DRAIN; m_idle = 0; end
        M_DRAIN: begin
          if (!i_sleep_req) m_mode = M_RUN;
          else if (!idle) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == IDLE_CYC) begin m_mode = M_UP; m_lvl = 1; m_wait = 0; end
          end
        end
        M_UP: begin
          if (a[m_lvl-1]) begin
            if (m_lvl == 4) m_mode = M_SLEEP;
            else begin m_lvl++; m_wait = 0; end
          end else if (m_wait == TIMEOUT - 1) to_abort = 1'b1;
          else m_wait++;
        end
        M_SLEEP: if (!i_sleep_req) begin m_mode = M_DOWN; m_lvl = 3; m_wait = 0; end
        M_DOWN: begin
          if (!a[m_lvl]) begin
            if (m_lvl == 0) m_mode = M_RUN;
            else begin m_lvl--; m_wait = 0; end
          end else if (m_wait == TIMEOUT - 1) to_abort = 1'b1;
          else m_wait++;
        end
        M_ABORT: if (a == 4'b0000) m_mode = M_RUN;
        default: m_mode = M_RUN;
      endcase
      if (to_abort) begin m_mode = M_ABORT; m_blk = 1'b1; m_err = 1'b1; end
      else if (!i_sleep_req) m_blk = 1'b0;
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [6:0] v;
    bit ladder;
    ladder = (m_mode == M_UP) || (m_mode == M_SLEEP) || (m_mode == M_DOWN);
    v[0] = (m_mode != M_RUN);
    for (int i = 0; i < 4; i++) v[i+1] = ladder && (i < m_lvl);
    v[5] = (m_mode == M_SLEEP);
    v[6] = m_err;
    return v;
  endfunction

  initial begin
    logic [6:0] v;
    exp_prev = 'x;
    forever begin
      @(posedge i_clk);
      cyc++;
      model_step();
      v = model_vec();
      if (v !== exp_prev) begin
        exp_q.push_back('{cyc: cyc, vec: v});
        exp_prev = v;
      end
    end
  end

  initial begin
    logic [6:0] v, mon_prev;
    ev_t e;
    mon_prev = 'x;
    @(posedge i_clk);
    forever begin
      @(negedge i_clk);
      v = dut_vec();
      if (v !== mon_prev) begin
        mon_prev = v;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_event: cycle %0d vec %b, expected no change", cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (e.vec === v && e.cyc == cyc) n_pass++;
          else $display("FAIL out_event: cycle %0d vec %b, expected cycle %0d vec %b",
                        cyc, v, e.cyc, e.vec);
        end
      end
    end
  end

  // Stimulus: bus traffic and ack responders that echo each request after dly cycles.
  logic [7:0] hist[4];
  int         dly[4];
  bit         stuck_en[4];
  logic       stuck_val[4];
  int         busy_pct = 0;
  int         force_busy = 0;
  int         first_hi[7], first_lo[7], hi_cnt[7];

  task automatic step();
    logic [3:0] req, ack;
    @(negedge i_clk);
    req = {o_ahb_src_sleep_req, o_ahb_sink_sleep_req, o_apb_src_sleep_req, o_apb_sink_sleep_req};
    for (int i = 0; i < 4; i++) begin
      hist[i] = {hist[i][6:0], req[i]};
      ack[i]  = stuck_en[i] ? stuck_val[i] : hist[i][dly[i]];
    end
    {i_ahb_src_sleep_ack, i_ahb_sink_sleep_ack, i_apb_src_sleep_ack, i_apb_sink_sleep_ack} = ack;
    if (force_busy > 0) begin
      i_htrans = 2'b10; i_hready = 1'b1; force_busy--;
    end else if ($urandom_range(0, 99) < busy_pct) begin
      i_htrans = {1'b1, 1'($urandom_range(0, 1))};
      i_hready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin i_htrans[1] = 1'b0; i_hready = 1'b0; end
    end else begin
      i_htrans = {1'b0, 1'($urandom_range(0, 1))}; i_hready = 1'b1;
    end
  endtask

  task automatic trace(input int n);
    logic [6:0] v;
    for (int j = 0; j < 7; j++) begin first_hi[j] = -1; first_lo[j] = -1; hi_cnt[j] = 0; end
    for (int k = 0; k < n; k++) begin
      step();
      v = dut_vec();
      for (int j = 0; j < 7; j++) begin
        if (v[j] === 1'b1) begin
          if (first_hi[j] < 0) first_hi[j] = k;
          hi_cnt[j]++;
        end else if (first_lo[j] < 0) first_lo[j] = k;
      end
    end
  endtask

  task automatic settle();
    i_sleep_req = 1'b0; force_busy = 0; busy_pct = 0;
    for (int i = 0; i < 4; i++) begin stuck_en[i] = 1'b0; dly[i] = 1; end
    trace(30);
  endtask

  initial begin
    i_rst = 1'b1; i_sleep_req = 1'b0; i_htrans = 2'b00; i_hready = 1'b1;
    {i_ahb_src_sleep_ack, i_ahb_sink_sleep_ack, i_apb_src_sleep_ack, i_apb_sink_sleep_ack} = 4'b0;
    for (int i = 0; i < 4; i++) begin
      hist[i] = 8'd0; dly[i] = 1; stuck_en[i] = 1'b0; stuck_val[i] = 1'b0;
    end
    trace(3);
    i_rst = 1'b0;
    check_int("reset_outputs", int'(dut_vec()), 0);

    i_sleep_req = 1'b1;
    trace(20);
    check_int("entry_gate", first_hi[0], 0);
    check_int("entry_apb_sink", first_hi[1], 4);
    check_int("entry_apb_src", first_hi[2], 6);
    check_int("entry_ahb_sink", first_hi[3], 8);
    check_int("entry_ahb_src", first_hi[4], 10);
    check_int("entry_sleep_ack", first_hi[5], 12);
    check_int("entry_no_timeout", hi_cnt[6], 0);

    i_sleep_req = 1'b0;
    trace(14);
    check_int("wake_sleep_ack_low", first_lo[5], 0);
    check_int("wake_ahb_src", first_lo[4], 0);
    check_int("wake_ahb_sink", first_lo[3], 2);
    check_int("wake_apb_src", first_lo[2], 4);
    check_int("wake_apb_sink", first_lo[1], 6);
    check_int("wake_gate_release", first_lo[0], 8);

    settle();
    i_sleep_req = 1'b1;
    trace(2);
    force_busy = 3;
    trace(12);
    check_int("busy_apb_sink", first_hi[1], 7);

    settle();
    stuck_en[2] = 1'b1; stuck_val[2] = 1'b0;
    i_sleep_req = 1'b1;
    trace(30);
    check_int("to_ahb_sink_enter", first_hi[3], 8);
    check_int("to_err_cycle", first_hi[6], 24);
    check_int("to_err_width", hi_cnt[6], 1);
    trace(20);
    check_int("to_no_redrain", hi_cnt[0], 0);
    stuck_en[2] = 1'b0;
    i_sleep_req = 1'b0;
    trace(1);
    i_sleep_req = 1'b1;
    trace(30);
    check_int("to_retry_sleep", first_hi[5], 12);

    settle();
    i_sleep_req = 1'b1;
    trace(7);
    check_int("drop_apb_src", first_hi[2], 6);
    i_sleep_req = 1'b0;
    trace(30);
    check_int("drop_sleep_pulse", hi_cnt[5], 1);
    check_int("drop_sleep_at", first_hi[5], 5);
    check_int("drop_gate_end", int'(o_bus_gate), 0);

    settle();
    i_sleep_req = 1'b1;
    trace(11);
    check_int("rst_ahb_src", first_hi[4], 10);
    i_rst = 1'b1; i_sleep_req = 1'b0;
    trace(1);
    check_int("rst_outputs", int'(dut_vec()), 0);
    i_rst = 1'b0;

    settle();
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      for (int i = 0; i < 4; i++) begin
        dly[i] = $urandom_range(0, 3);
        stuck_en[i] = ($urandom_range(0, 9) == 0);
        stuck_val[i] = 1'($urandom_range(0, 1));
      end
      busy_pct = $urandom_range(0, 60);
      i_sleep_req = 1'($urandom_range(0, 1));
      len = $urandom_range(10, 60);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) i_sleep_req = !i_sleep_req;
        i_rst = ($urandom_range(0, 299) == 0);
        step();
      end
      i_rst = 1'b0;
    end

    settle();
    step();
    #1;
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bridge_sleep_seq.md
# bridge_sleep_seq

Single-clock sleep/wake sequencer for the two SoC bus bridges: the AHB-to-AHB bridge and the AHB-to-APB bridge.
- On a level sleep request from the AON subsystem it does the following, in order:
  - gates new AHB traffic;
  - waits for the bus to drain;
  - walks each bridge's sink-side and source-side sleep handshakes in a fixed order;
  - acknowledges the request.
- Wake reverses the order.
- A per-step timeout aborts a stuck handshake cleanly.
- Sits in the SoC top between `aon_subsystem` and the bridge sleep ports.

## Interface
Parameters:
- `IDLE_CYC`, 4: consecutive idle bus cycles required before sleep entry (1..255).
- `TIMEOUT`, 16: maximum cycles to wait for any single ack edge (2..255).

Ports:
- `i_clk`, in, 1: clock. One clock domain; reset is synchronous and active-high.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_sleep_req`, in, 1: level from AON. 1 = enter sleep, 0 = run/wake.
- `i_htrans`, in, 2: source AHB transfer type, monitored only.
- `i_hready`, in, 1: source AHB ready, monitored only.
- `o_bus_gate`, out, 1: 1 = the MCU master must not issue NONSEQ.
- `o_apb_sink_sleep_req`, `o_apb_src_sleep_req`, out, 1 each: AHB-APB bridge requests.
- `i_apb_sink_sleep_ack`, `i_apb_src_sleep_ack`, in, 1 each: the matching acks.
- `o_ahb_sink_sleep_req`, `o_ahb_src_sleep_req`, out, 1 each: AHB-AHB bridge requests.
- `i_ahb_sink_sleep_ack`, `i_ahb_src_sleep_ack`, in, 1 each: the matching acks.
- `o_sleep_ack`, out, 1: 1 only in SLEEP.
- `o_timeout_err`, out, 1: one-cycle pulse when a step times out.

## Operation
- All outputs are registered.
- Reset forces state RUN and all outputs 0.
- An idle bus cycle is a cycle with `i_htrans[1]==0` and `i_hready==1`.
- Each sleep request is held until the end of SLEEP. The bridge's sleep request is then deasserted during wake.

States and transitions:
- **RUN**: all requests 0. `i_sleep_req==1` moves to DRAIN.
- **DRAIN**:
  - `o_bus_gate=1`.
  - An 8-bit idle counter increments on each idle cycle and clears on any non-idle cycle.
  - When the count reaches `IDLE_CYC`, go to APB_SINK.
  - If `i_sleep_req` drops, go to RUN (gate released, no handshakes).
- **Entry steps**: APB_SINK, APB_SRC, AHB_SINK, AHB_SRC.
  - Each step sets its own request to 1. Earlier requests stay 1.
  - The step advances when its ack is sampled 1.
  - Order is downstream first: the APB bridge before the AHB bridge, sink side before source side.
- **SLEEP**:
  - `o_sleep_ack=1`, `o_bus_gate=1`, all four requests 1.
  - `i_sleep_req==0` moves to W_AHB_SRC.
- **Wake steps**: W_AHB_SRC, W_AHB_SINK, W_APB_SRC, W_APB_SINK.
  - Each step clears its request and waits for its ack to be sampled 0.
  - After W_APB_SINK completes, go to RUN and release `o_bus_gate`.
- **Timeout**:
  - An 8-bit step counter clears on every state change and increments each cycle in an entry or wake step.
  - At count `TIMEOUT-1` with the awaited ack value still absent, go to ABORT and pulse `o_timeout_err` (exactly one cycle).
- **ABORT**:
  - All four requests 0, `o_bus_gate=1`.
  - Wait until all four acks are 0, with no timeout.
  - Then go to RUN.
  - A retry requires `i_sleep_req` to be 0 for at least one cycle first. A sticky internal flag blocks DRAIN entry until `i_sleep_req` is seen low.
- **`i_sleep_req` drops during an entry step**: entry completes to SLEEP, and wake starts on the next cycle. Handshakes are never abandoned mid-step.
- **`i_sleep_req` rises again during wake**: wake completes to RUN, then a new sleep entry starts.
- **Already-high ack**: an ack that is already at the awaited value when the step is entered advances on the first sampled cycle.
- **Reset mid-sequence**: returns to RUN with all requests dropped immediately. The bridges handle the dropped requests themselves.

## Timing
- Request outputs change on the clock edge at which the step state is entered.
- The ack is sampled at each following edge.
- Minimum step length is 1 cycle (ack already valid). With an ack that responds one cycle after the request, a step takes 2 cycles.

Entry from an idle bus, with `i_sleep_req` rising before edge 0 and 1-cycle ack responders:
- DRAIN covers cycles 0..3.
- APB_SINK starts at cycle 4, then APB_SRC at 6, AHB_SINK at 8, AHB_SRC at 10.
- `o_sleep_ack=1` from cycle 12.

Wake with `i_sleep_req` low before edge W and the same responders:
- `o_sleep_ack` is 0 from W.
- RUN is reached, with the gate released, at W+8.

`o_bus_gate` asserts in the first DRAIN cycle.

## Test plan
1. **Nominal entry.** Idle bus, 1-cycle ack responders, `IDLE_CYC=4`. Raise `i_sleep_req`.
   - Requests assert in the order apb_sink, apb_src, ahb_sink, ahb_src, 2 cycles apart.
   - `o_sleep_ack=1` 12 cycles after the request; `o_timeout_err` never pulses.
2. **Busy bus.** Same setup, but `i_htrans=NONSEQ` for 3 cycles in the middle of DRAIN.
   - The idle count restarts, so 4 fresh idle cycles are needed before APB_SINK.
   - No request is asserted while the bus is non-idle.
3. **Wake.** From SLEEP, drop `i_sleep_req`.
   - Requests deassert in the order ahb_src, ahb_sink, apb_src, apb_sink.
   - `o_bus_gate` falls 8 cycles after the drop.
4. **Timeout.** Hold `i_ahb_sink_sleep_ack=0`, `TIMEOUT=16`.
   - `o_timeout_err` is a single pulse 16 cycles after AHB_SINK is entered.
   - All requests return to 0; RUN is reached once the acks are 0.
   - No new DRAIN occurs until `i_sleep_req` toggles low and then high.
5. **Drop during entry.** Drop `i_sleep_req` in APB_SRC.
   - Entry completes, `o_sleep_ack` pulses for 1 cycle, then the full wake sequence runs.
6. **Reset.** Assert `i_rst` for 1 cycle while in AHB_SRC.
   - All outputs are 0 on the next cycle; state is RUN.
